// File: rtl/fsm_pwm_pkg.sv
// Shared constants, duty width and ramp-state enum for the soft-start PWM path.
// Latency: n/a (declarations and one combinational helper).
// Backpressure: n/a.
package fsm_pwm_pkg;

  localparam int DUTY_W    = 7;
  localparam int PWM_STEPS = 100;

  localparam logic [DUTY_W-1:0] PCT_0   = 7'd0;
  localparam logic [DUTY_W-1:0] PCT_30  = 7'd30;
  localparam logic [DUTY_W-1:0] PCT_50  = 7'd50;
  localparam logic [DUTY_W-1:0] PCT_100 = 7'd100;

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN,
    HOLD
  } pwm_state_e;

  // Move duty toward target by at most step, landing exactly on target when
  // the gap is smaller than step. Widened to 8 bits so duty+step cannot wrap.
  function automatic logic [DUTY_W-1:0] slew_duty(
    input logic [DUTY_W-1:0] duty,
    input logic [DUTY_W-1:0] target,
    input logic [7:0]        step
  );
    logic [7:0] d8;
    logic [7:0] t8;
    logic [7:0] gap;
    logic [7:0] res;
    d8  = {1'b0, duty};
    t8  = {1'b0, target};
    gap = 8'd0;
    res = t8;
    if (t8 > d8) begin
      gap = t8 - d8;
      if (gap > step) res = d8 + step;
    end else if (d8 > t8) begin
      gap = d8 - t8;
      if (gap > step) res = d8 - step;
    end
    if (res > 8'd100) res = 8'd100;
    return res[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_dead_time.sv
// Splits a PWM stream into a gated complementary pair with dead-time after each edge.
// Latency: 1 clk from pwm_i to pwm_p_o / pwm_n_o (outputs registered).
// Backpressure: none; follows pwm_i every cycle.
module pwm_dead_time #(
  parameter int DEAD_CYC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pwm_i,
  output logic pwm_p_o,
  output logic pwm_n_o
);

  localparam int            DW      = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [DW-1:0] DT_LOAD = (DEAD_CYC > 1) ? DW'(DEAD_CYC - 1) : '0;

  logic          prev_q;
  logic [DW-1:0] dt_q;
  logic [DW-1:0] dt_d;
  logic          edge_det;
  logic          blank;
  logic          p_q;
  logic          n_q;

  // The edge cycle itself is the first blanked cycle, so the counter only
  // needs to cover the remaining DEAD_CYC-1 cycles.
  assign edge_det = pwm_i ^ prev_q;
  assign blank    = (DEAD_CYC != 0) && (edge_det || (dt_q != '0));

  // dead-time down-counter, reloaded on every input edge
  always_comb begin
    dt_d = dt_q;
    if (edge_det)          dt_d = DT_LOAD;
    else if (dt_q != '0)   dt_d = dt_q - DW'(1);
  end

  // both legs forced low while blanking so they are never high together
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
      dt_q   <= '0;
      p_q    <= 1'b0;
      n_q    <= 1'b0;
    end else begin
      prev_q <= pwm_i;
      dt_q   <= dt_d;
      p_q    <= pwm_i & ~blank;
      n_q    <= ~pwm_i & ~blank;
    end
  end

  assign pwm_p_o = p_q;
  assign pwm_n_o = n_q;

endmodule

// File: rtl/pwm_rampa_motor.sv
// Level request (30/50/100 %) to slew-limited fixed-period PWM; optional PWM_COMPLEMENTARY_EN adds pwm_n.
// Latency: request->target 1 clk; target->duty at next period wrap; counter->pwm_out 1 clk.
// Backpressure: none; free-running, duty only changes at period boundaries.
module pwm_rampa_motor
  import fsm_pwm_pkg::*;
#(
  parameter int PRE_DIV   = 1,
  parameter int SLEW_STEP = 5,
  parameter int DEAD_CYC  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              out_30,
  input  logic              out_50,
  input  logic              out_100,
  output logic              pwm_out,
  output logic [DUTY_W-1:0] duty_actual,
  output logic              at_target,
  output logic              fault
`ifdef PWM_COMPLEMENTARY_EN
  ,
  output logic              pwm_n
`endif
);

  localparam int                PW       = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PW-1:0]     PRE_LAST = PW'(PRE_DIV - 1);
  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PWM_STEPS - 1);
  localparam logic [7:0]        STEP8    = 8'(SLEW_STEP);

  if (PRE_DIV < 1 || SLEW_STEP < 1 || SLEW_STEP > 100 || DEAD_CYC < 0) begin : g_param_check
    $error("pwm_rampa_motor: parameter out of range");
  end

  logic [PW-1:0]     pre_q;
  logic [DUTY_W-1:0] cnt_q;
  logic              tick;
  logic              wrap;

  logic [DUTY_W-1:0] target_d;
  logic [DUTY_W-1:0] target_q;
  logic              fault_d;
  logic              fault_q;

  pwm_state_e        state_q;
  logic [DUTY_W-1:0] duty_d;
  logic [DUTY_W-1:0] duty_q;

  logic              pwm_d;
  logic              at_target_q;

  assign tick = (pre_q == PRE_LAST);
  assign wrap = tick && (cnt_q == CNT_LAST);

  // prescaler tick and 0..99 period counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + PW'(1);
      if (tick) cnt_q <= wrap ? '0 : cnt_q + DUTY_W'(1);
    end
  end

  // one-hot level decode; conflicting requests keep the old target and flag fault
  always_comb begin
    target_d = target_q;
    fault_d  = 1'b0;
    case ({out_100, out_50, out_30})
      3'b000:  target_d = PCT_0;
      3'b001:  target_d = PCT_30;
      3'b010:  target_d = PCT_50;
      3'b100:  target_d = PCT_100;
      default: fault_d  = 1'b1;
    endcase
  end

  // target and fault registers
  always_ff @(posedge clk) begin
    if (reset) begin
      target_q <= PCT_0;
      fault_q  <= 1'b0;
    end else begin
      target_q <= target_d;
      fault_q  <= fault_d;
    end
  end

  // The boundary uses the already-registered target, so a request arriving on
  // the wrap cycle is only seen at the following boundary.
  assign duty_d = slew_duty(duty_q, target_q, STEP8);

  // duty slew and ramp state, both advanced only at period boundaries
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      duty_q  <= PCT_0;
    end else if (wrap) begin
      duty_q <= duty_d;
      if (duty_d == target_q) state_q <= (duty_d == PCT_0) ? IDLE : HOLD;
      else if (duty_d < target_q) state_q <= RAMP_UP;
      else state_q <= RAMP_DOWN;
    end
  end

  // IDLE always has duty 0, so gating on state only reinforces a quiet output.
  // cnt never exceeds 99, so duty 100 keeps the drive high across the wrap.
  assign pwm_d = (state_q != IDLE) && (cnt_q < duty_q);

  // registered at-target flag
  always_ff @(posedge clk) begin
    if (reset) at_target_q <= 1'b1;
    else       at_target_q <= (duty_q == target_q);
  end

`ifdef PWM_COMPLEMENTARY_EN
  pwm_dead_time #(
    .DEAD_CYC (DEAD_CYC)
  ) u_dead_time (
    .clk     (clk),
    .reset   (reset),
    .pwm_i   (pwm_d),
    .pwm_p_o (pwm_out),
    .pwm_n_o (pwm_n)
  );
`else
  logic pwm_q;

  // registered PWM drive
  always_ff @(posedge clk) begin
    if (reset) pwm_q <= 1'b0;
    else       pwm_q <= pwm_d;
  end

  assign pwm_out = pwm_q;
`endif

  assign duty_actual = duty_q;
  assign at_target   = at_target_q;
  assign fault       = fault_q;

endmodule

// File: doc/pwm_rampa_motor.md
# pwm_rampa_motor

Downstream consumer of the soft-start FSM level outputs (`out_30`, `out_50`, `out_100`). It converts the requested speed level into a fixed-period PWM drive for the motor stage. Duty moves toward the requested level with a bounded slew and is updated only at PWM period boundaries, so the output never glitches. It runs on the same prescaled clock domain as the FSM and sits between the FSM and the top-level output pins.

## Interface
Parameters:
- `PRE_DIV`, default 1: clk cycles per PWM counter step (≥1).
- `SLEW_STEP`, default 5: maximum duty change in percent per PWM period (1..100).
- `DEAD_CYC`, default 2: dead-time in clk cycles. Used only with `PWM_COMPLEMENTARY_EN`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: synchronous reset, active-high.
- `out_30`, input, 1: 30 % level request from the FSM.
- `out_50`, input, 1: 50 % level request.
- `out_100`, input, 1: 100 % level request.
- `pwm_out`, output, 1: registered PWM drive.
- `duty_actual`, output, 7: currently applied duty in percent (0..100).
- `at_target`, output, 1: high when the applied duty equals the target duty.
- `fault`, output, 1: high while more than one level request is asserted.
- `pwm_n`, output, 1: complementary drive. Present only with `PWM_COMPLEMENTARY_EN`.

## Operation
- **Target decode**, registered every clk:
  - No request high → target 0.
  - Exactly one of `out_30`/`out_50`/`out_100` high → target 30, 50 or 100 respectively.
  - Two or more high → target register holds its previous value and `fault`=1. `fault` clears on the first clk the requests are valid again.
- **Period counter** `cnt`:
  - Counts 0..99. It advances once every `PRE_DIV` clk cycles via an internal tick.
  - It wraps 99→0. A wrap is a period boundary.
- **Duty update**, only on the tick in which `cnt` wraps to 0:
  - Target > duty → duty = min(duty+`SLEW_STEP`, target).
  - Target < duty → duty = max(duty−`SLEW_STEP`, target).
  - Slew arithmetic is done in 8 bits so it cannot overflow. The result is clamped to the range 0..100 and never overshoots the target.
- **State machine** (`state`), evaluated at period boundaries:
  - IDLE: duty=0 and target=0.
  - RAMP_UP: duty < target.
  - RAMP_DOWN: duty > target.
  - HOLD: duty = target ≠ 0.
  - Transitions are taken purely by comparing the new duty against the target. A target change in the middle of a ramp redirects the ramp at the next boundary.
- **PWM output**: `pwm_out` = registered (`cnt` < duty).
  - Duty 0 → `pwm_out` is constantly low.
  - Duty 100 → `pwm_out` is constantly high, with no pulse dropout at the wrap.
- `at_target` = (duty == target), registered.

## Timing
- **Reset values**:
  - `cnt`=0, duty=0, target=0, state IDLE.
  - `pwm_out`=0, `duty_actual`=0, `at_target`=1, `fault`=0, `pwm_n`=0.
- **Reset in mid-operation**: all outputs take their reset values on the next rising edge while `reset` is high. Normal operation restarts with `cnt`=0.
- **Request → target latency**: 1 clk.
- **Target → first duty change**: at the next period boundary, which is at most 100·`PRE_DIV` clk after the target changes.
- **Duty → `pwm_out` latency**: 1 clk after the counter value.
- **Full ramp 0→100** with `SLEW_STEP`=5: 20 periods.
- **Simultaneous events**: a request change on the same clk as a wrap is not used for that boundary. The boundary uses the previously registered target.

## Configuration
- `PWM_COMPLEMENTARY_EN` defined:
  - `pwm_n` port exists and carries the inverse of `pwm_out`.
  - After every edge of `pwm_out`, the newly-high output is held low for `DEAD_CYC` clk, so both outputs are low during that time. They are never high simultaneously.
  - With duty 0 or 100, `pwm_n` is the steady inverse of `pwm_out`.
- `PWM_COMPLEMENTARY_EN` not defined:
  - No `pwm_n` port and no dead-time logic.
  - `DEAD_CYC` is ignored.

## Structure
- **Shared package `fsm_pwm_pkg`** holds:
  - Constants `PCT_0`, `PCT_30`, `PCT_50`, `PCT_100` and `PWM_STEPS`=100.
  - The duty width (7).
  - The state enum {IDLE, RAMP_UP, RAMP_DOWN, HOLD}.
- **Sub-module `pwm_dead_time`**: takes `pwm_out` and produces the gated complementary pair. It is instantiated only under `PWM_COMPLEMENTARY_EN`.
- All other logic (prescale tick, counter, decode, slew, state machine) lives in `pwm_rampa_motor`.

## Test plan
All scenarios use `PRE_DIV`=1 and `SLEW_STEP`=5 unless stated otherwise.
- **Reset**: hold `reset` for 3 clk, with any inputs → all outputs at reset values; `at_target`=1.
- **Ramp from idle**: `out_30`=1 from idle → duty goes 5, 10, …, 30 at successive boundaries and reaches 30 after 6 periods. `at_target` rises. `pwm_out` is high for 30 of every 100 clk in HOLD.
- **Step between levels**: `out_100` after HOLD at 50 → duty ramps in 10 periods; `pwm_out` is constantly high with no low cycle at the wrap. Then drop all requests → RAMP_DOWN to 0 and IDLE; `pwm_out` stays low.
- **Invalid request**: `out_30` and `out_50` together while at HOLD 50 → `fault`=1, target stays 50, duty unchanged. Releasing `out_30` → `fault`=0 one clk later.
- **Reset during ramp**: assert `reset` mid-ramp at duty 35 → next edge gives duty 0, `pwm_out` 0, `cnt` 0. The ramp restarts from 0 after release.
- **Complementary mode**: with `PWM_COMPLEMENTARY_EN`, `DEAD_CYC`=2 and duty 50 → `pwm_n` is the inverse of `pwm_out` with both outputs low for 2 clk after each edge, and never both high.
